// File: rtl/output_buffer_if.sv
// Host-side read port of the SHA-256 output buffer.
// Carries the eight core hash words, the load enable, the word select and the registered read data.
interface output_buffer_if #(
  parameter int WIDTH = 32
);
  logic [3:0]       addr;
  logic             en;
  logic [WIDTH-1:0] in_A;
  logic [WIDTH-1:0] in_B;
  logic [WIDTH-1:0] in_C;
  logic [WIDTH-1:0] in_D;
  logic [WIDTH-1:0] in_E;
  logic [WIDTH-1:0] in_F;
  logic [WIDTH-1:0] in_G;
  logic [WIDTH-1:0] in_H;
  logic [WIDTH-1:0] out_var;

  modport master (
    output addr, en, in_A, in_B, in_C, in_D, in_E, in_F, in_G, in_H,
    input  out_var
  );

  modport slave (
    input  addr, en, in_A, in_B, in_C, in_D, in_E, in_F, in_G, in_H,
    output out_var
  );
endinterface

// File: rtl/output_buffer.sv
// Snapshot bank for the eight SHA-256 hash words (A..H) with a registered
// one-word read mux. With en high, the live word is bypassed to the output on the load edge.
module output_buffer #(
  parameter int          WIDTH  = 32,
  parameter int unsigned NWORDS = 8
) (
  input logic           clk,
  input logic           rst,
  output_buffer_if.slave bus
);

  logic [WIDTH-1:0] bank [1:NWORDS];
  logic [WIDTH-1:0] live [1:NWORDS];
  logic [WIDTH-1:0] live_sel;
  logic [WIDTH-1:0] bank_sel;
  logic [WIDTH-1:0] out_q;

  always_comb begin
    live[1] = bus.in_A;
    live[2] = bus.in_B;
    live[3] = bus.in_C;
    live[4] = bus.in_D;
    live[5] = bus.in_E;
    live[6] = bus.in_F;
    live[7] = bus.in_G;
    live[8] = bus.in_H;
  end

  // Addresses outside 1..NWORDS match no entry and fall through to zero.
  always_comb begin
    live_sel = '0;
    bank_sel = '0;
    for (int unsigned k = 1; k <= NWORDS; k++) begin
      if (bus.addr == 4'(k)) begin
        live_sel = live[k];
        bank_sel = bank[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 1; k <= NWORDS; k++) begin
        bank[k] <= '0;
      end
      out_q <= '0;
    end else if (bus.en) begin
      for (int unsigned k = 1; k <= NWORDS; k++) begin
        bank[k] <= live[k];
      end
      out_q <= live_sel;
    end else begin
      out_q <= bank_sel;
    end
  end

  assign bus.out_var = out_q;

endmodule

// File: tb/tb_output_buffer.sv
// Self-checking bench for output_buffer: directed vector table, a reset corner
// sequence and a randomized phase checked against a small reference model.
module tb_output_buffer;

  typedef logic [7:0][31:0] words_t;   // [0]=A .. [7]=H

  typedef struct {
    logic        rst;
    logic        en;
    logic [3:0]  addr;
    words_t      w;
    logic [31:0] exp;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  output_buffer_if #(.WIDTH(32)) bus ();

  output_buffer #(.WIDTH(32), .NWORDS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] sb_exp  [$];
  string       sb_name [$];

  vec_t vecs [$];

  words_t pat;
  words_t ones;
  words_t mbank;

  function automatic words_t mk(input logic [31:0] a, b, c, d, e, f, g, h);
    words_t r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    r[4] = e; r[5] = f; r[6] = g; r[7] = h;
    return r;
  endfunction

  function automatic vec_t v(input logic r, input logic e, input logic [3:0] a,
                             input words_t w, input logic [31:0] x, input string n);
    vec_t t;
    t.rst = r; t.en = e; t.addr = a; t.w = w; t.exp = x; t.name = n;
    return t;
  endfunction

  // Drive one cycle of stimulus, push its expectation, then check just after the edge.
  task automatic apply(input vec_t t);
    rst      = t.rst;
    bus.en   = t.en;
    bus.addr = t.addr;
    bus.in_A = t.w[0]; bus.in_B = t.w[1]; bus.in_C = t.w[2]; bus.in_D = t.w[3];
    bus.in_E = t.w[4]; bus.in_F = t.w[5]; bus.in_G = t.w[6]; bus.in_H = t.w[7];
    sb_exp.push_back(t.exp);
    sb_name.push_back(t.name);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic check_out();
    logic [31:0] e;
    string       n;
    n_checks++;
    if (sb_exp.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: out_var=%h with no expectation queued", bus.out_var);
    end else begin
      e = sb_exp.pop_front();
      n = sb_name.pop_front();
      if (bus.out_var !== e) begin
        n_fail++;
        $display("FAIL %s: out_var=%h expected=%h (t=%0t)", n, bus.out_var, e, $time);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    pat  = mk(32'd1, 32'd2, 32'd3, 32'd4, 32'd55, 32'd6, 32'd7, 32'd8);
    ones = mk('1, '1, '1, '1, '1, '1, '1, '1);

    // Reset, then every address reads zero from the cleared bank.
    vecs.push_back(v(1'b1, 1'b0, 4'd1, pat, 32'd0, "reset"));
    for (int i = 1; i <= 8; i++)
      vecs.push_back(v(1'b0, 1'b0, 4'(i), pat, 32'd0, $sformatf("post_reset_addr%0d", i)));
    // Load with bypass.
    vecs.push_back(v(1'b0, 1'b1, 4'd1, pat, 32'd1,  "load_bypass_A"));
    vecs.push_back(v(1'b0, 1'b1, 4'd5, pat, 32'd55, "load_bypass_E"));
    // Snapshot held while inputs change under en=0.
    for (int i = 1; i <= 8; i++)
      vecs.push_back(v(1'b0, 1'b0, 4'(i), ones, pat[i-1], $sformatf("held_addr%0d", i)));
    // Unmapped addresses.
    vecs.push_back(v(1'b0, 1'b0, 4'd0,  ones, 32'd0, "unmapped_0"));
    vecs.push_back(v(1'b0, 1'b0, 4'd9,  ones, 32'd0, "unmapped_9"));
    vecs.push_back(v(1'b0, 1'b0, 4'd15, ones, 32'd0, "unmapped_15"));
    vecs.push_back(v(1'b0, 1'b1, 4'd0,  ones, 32'd0, "bypass_unmapped_0"));
    vecs.push_back(v(1'b0, 1'b0, 4'd3,  pat,  32'hFFFF_FFFF, "reload_ones_C"));
    // Reset wins over en.
    vecs.push_back(v(1'b1, 1'b1, 4'd1, ones, 32'd0, "rst_over_en"));
    vecs.push_back(v(1'b0, 1'b0, 4'd5, ones, 32'd0, "after_rst_E"));
    // Back-to-back loads.
    vecs.push_back(v(1'b0, 1'b1, 4'd8, mk(0,0,0,0,0,0,0,32'd8), 32'd8, "b2b_H_8"));
    vecs.push_back(v(1'b0, 1'b1, 4'd8, mk(0,0,0,0,0,0,0,32'd9), 32'd9, "b2b_H_9"));
    vecs.push_back(v(1'b0, 1'b0, 4'd8, pat, 32'd9, "b2b_H_held"));

    rst = 1'b1; bus.en = 1'b0; bus.addr = '0;
    bus.in_A = '0; bus.in_B = '0; bus.in_C = '0; bus.in_D = '0;
    bus.in_E = '0; bus.in_F = '0; bus.in_G = '0; bus.in_H = '0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) apply(vecs[i]);

    // Hand sequence: reset in the middle of a read sweep discards the snapshot.
    apply(v(1'b0, 1'b1, 4'd2, pat, 32'd2, "seq_load_B"));
    apply(v(1'b0, 1'b0, 4'd7, ones, 32'd7, "seq_read_G"));
    apply(v(1'b1, 1'b0, 4'd4, ones, 32'd0, "seq_mid_reset"));
    for (int i = 1; i <= 8; i++)
      apply(v(1'b0, 1'b0, 4'(i), ones, 32'd0, $sformatf("seq_cleared_addr%0d", i)));

    // Randomized phase against a reference model of the bank.
    mbank = '0;
    for (int n = 0; n < 60; n++) begin
      vec_t t;
      words_t w;
      logic [31:0] x;
      logic r, e;
      logic [3:0] a;
      for (int k = 0; k < 8; k++) w[k] = $urandom;
      r = ($urandom_range(0, 19) == 0);
      e = ($urandom_range(0, 2) == 0);
      a = 4'($urandom_range(0, 15));
      if (r) begin
        x = '0;
        mbank = '0;
      end else if (e) begin
        x = (a >= 4'd1 && a <= 4'd8) ? w[a - 4'd1] : 32'd0;
        mbank = w;
      end else begin
        x = (a >= 4'd1 && a <= 4'd8) ? mbank[a - 4'd1] : 32'd0;
      end
      t = v(r, e, a, w, x, $sformatf("rand%0d_addr%0d", n, a));
      apply(t);
    end

    if (sb_exp.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_exp.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
